// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART frame transmitter: parity modes, FSM
// state encoding and frame-length arithmetic.
package uart_tx_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  function automatic int frame_len(input int data_w, input int parity_mode, input int stop_bits);
    return 1 + data_w + ((parity_mode != PAR_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/tx_fifo.sv
// Power-of-two synchronous FIFO with occupancy level; full is derived from
// the registered level so a same-cycle pop never frees a slot early.
module tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic [LW-1:0]    level_d;
  logic             do_push_s;
  logic             do_pop_s;

  assign full_o    = (level_q == LW'(DEPTH));
  assign empty_o   = (level_q == LW'(0));
  assign level_o   = level_q;
  assign head_o    = mem_q[rd_ptr_q];
  assign do_push_s = push_i & ~full_o;
  assign do_pop_s  = pop_i & ~empty_o;

  always_comb begin
    level_d = level_q;
    case ({do_push_s, do_pop_s})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      level_q <= level_d;
      if (do_push_s) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop_s)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  // Storage has no reset; only the pointers define valid contents.
  always_ff @(posedge clk_i) begin
    if (rst_n_i && do_push_s) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_frame_tx.sv
// UART frame transmitter: buffered words are serialised as start, data,
// optional parity and stop bits, advancing one bit per baud tick.
module uart_frame_tx
  import uart_tx_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int PARITY_MODE = 1,
  parameter int STOP_BITS   = 1,
  parameter int MSB_FIRST   = 0,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          Clk,
  input  logic                          RstN,
  input  logic                          TickTack,
  input  logic                          DinValid,
  input  logic [DATA_W-1:0]             Din,
  output logic                          DinReady,
  output logic                          DoutTx,
  output logic                          BusyFlag,
  output logic                          Done,
  output logic                          Overflow,
  output logic [$clog2(FIFO_DEPTH):0]   FifoLevel
);

  localparam int LW    = $clog2(FIFO_DEPTH) + 1;
  localparam int CNT_W = $clog2(frame_len(DATA_W, PARITY_MODE, STOP_BITS) + 1);

  if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
    $error("uart_frame_tx: DATA_W must be 5..9");
  end
  if (PARITY_MODE < PAR_NONE || PARITY_MODE > PAR_ODD) begin : g_bad_parity
    $error("uart_frame_tx: PARITY_MODE must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_frame_tx: STOP_BITS must be 1 or 2");
  end
  if (MSB_FIRST < 0 || MSB_FIRST > 1) begin : g_bad_order
    $error("uart_frame_tx: MSB_FIRST must be 0 or 1");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_frame_tx: FIFO_DEPTH must be a power of 2, at least 2");
  end

  logic [DATA_W-1:0] head_s;
  logic [LW-1:0]     level_s;
  logic              full_s;
  logic              empty_s;
  logic              push_s;
  logic              pop_s;
  logic              head_par_s;
  logic              next_bit_s;
  logic [DATA_W-1:0] shifted_s;

  tx_state_e         state_q;
  logic [DATA_W-1:0] shreg_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              parity_q;
  logic              dout_q;
  logic              done_q;
  logic              ovf_q;

  tx_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (Clk),
    .rst_n_i (RstN),
    .push_i  (push_s),
    .wdata_i (Din),
    .pop_i   (pop_s),
    .head_o  (head_s),
    .level_o (level_s),
    .full_o  (full_s),
    .empty_o (empty_s)
  );

  // Pops happen only on the tick that starts a frame: from IDLE or at the end of the last stop bit.
  assign push_s = DinValid & RstN;
  assign pop_s  = RstN & TickTack & ~empty_s &
                  ((state_q == ST_IDLE) ||
                   ((state_q == ST_STOP) && (cnt_q == CNT_W'(STOP_BITS))));

  assign head_par_s = (^head_s) ^ (PARITY_MODE == PAR_ODD);
  assign next_bit_s = (MSB_FIRST != 0) ? shreg_q[DATA_W-1] : shreg_q[0];
  assign shifted_s  = (MSB_FIRST != 0) ? (shreg_q << 1) : (shreg_q >> 1);

  assign DinReady  = ~full_s;
  assign DoutTx    = dout_q;
  assign Done      = done_q;
  assign Overflow  = ovf_q;
  assign FifoLevel = level_s;
  assign BusyFlag  = (state_q != ST_IDLE) | ~empty_s;

  always_ff @(posedge Clk) begin
    if (!RstN) begin
      state_q  <= ST_IDLE;
      shreg_q  <= '0;
      cnt_q    <= '0;
      parity_q <= 1'b0;
      dout_q   <= 1'b1;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (DinValid && full_s) ovf_q <= 1'b1;
      if (TickTack) begin
        case (state_q)
          ST_IDLE: begin
            if (pop_s) begin
              shreg_q  <= head_s;
              parity_q <= head_par_s;
              dout_q   <= 1'b0;
              state_q  <= ST_START;
            end
          end
          ST_START: begin
            dout_q  <= next_bit_s;
            shreg_q <= shifted_s;
            cnt_q   <= CNT_W'(1);
            state_q <= ST_DATA;
          end
          ST_DATA: begin
            if (cnt_q == CNT_W'(DATA_W)) begin
              if (PARITY_MODE != PAR_NONE) begin
                dout_q  <= parity_q;
                state_q <= ST_PARITY;
              end else begin
                dout_q  <= 1'b1;
                cnt_q   <= CNT_W'(1);
                state_q <= ST_STOP;
              end
            end else begin
              dout_q  <= next_bit_s;
              shreg_q <= shifted_s;
              cnt_q   <= cnt_q + CNT_W'(1);
            end
          end
          ST_PARITY: begin
            dout_q  <= 1'b1;
            cnt_q   <= CNT_W'(1);
            state_q <= ST_STOP;
          end
          ST_STOP: begin
            if (cnt_q == CNT_W'(STOP_BITS)) begin
              done_q <= 1'b1;
              cnt_q  <= '0;
              // A queued word starts immediately so frames run back to back.
              if (pop_s) begin
                shreg_q  <= head_s;
                parity_q <= head_par_s;
                dout_q   <= 1'b0;
                state_q  <= ST_START;
              end else begin
                state_q <= ST_IDLE;
              end
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          default: begin
            dout_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
